// File: rtl/dcache_sa_wb_pkg.sv
// Shared types and geometry helpers for the set-associative write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    RESPOND   = 2'd3
  } state_e;

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int offset_w, input int sets);
    return addr_w - offset_w - $clog2(sets);
  endfunction

  function automatic int calc_way_w(input int ways);
    return $clog2(ways);
  endfunction

endpackage

// File: rtl/dcache_sa_wb_if.sv
// Backing-memory req/ack bus; the cache is the master, the memory the slave.
interface dcache_sa_wb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_sa_wb_tag_match.sv
// Combinational compare of one set's valid+tag against a lookup tag, plus
// lowest-invalid-way search used for victim selection.
module dcache_tag_match #(
  parameter int WAYS  = 8,
  parameter int TAG_W = 28,
  parameter int WAY_W = 3
) (
  input  logic [WAYS-1:0]            valid_i,
  input  logic [WAYS-1:0][TAG_W-1:0] tags_i,
  input  logic [TAG_W-1:0]           tag_i,
  output logic                       hit_o,
  output logic [WAY_W-1:0]           hit_way_o,
  output logic [WAY_W-1:0]           first_invalid_o,
  output logic                       any_invalid_o
);

  logic [WAYS-1:0] match;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
      assign match[gi] = valid_i[gi] && (tags_i[gi] == tag_i);
    end
  endgenerate

  // Descending scan so the lowest-numbered way wins.
  always_comb begin
    hit_way_o       = '0;
    first_invalid_o = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_way_o = w[WAY_W-1:0];
      if (!valid_i[w]) first_invalid_o = w[WAY_W-1:0];
    end
  end

  assign hit_o         = |match;
  assign any_invalid_o = ~&valid_i;

endmodule

// File: rtl/dcache_sa_wb.sv
// Clocked set-associative data cache, one word per line, write-back and
// write-allocate, per-set round-robin replacement, req/ack miss handling.
module dcache_sa_wb
  import dcache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAYS     = 8,
  parameter int SETS     = 2,
  parameter int OFFSET_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              miss,
  dcache_sa_wb_if.master    mem
);

  localparam int IDX_W = calc_idx_w(SETS);
  localparam int TAG_W = calc_tag_w(ADDR_W, OFFSET_W, SETS);
  localparam int WAY_W = calc_way_w(WAYS);
  localparam int BLK_W = ADDR_W - OFFSET_W;

  // Line storage; tags and data are deliberately left uninitialised.
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];

  state_e            state_q, state_d;
  logic [BLK_W-1:0]  req_blk_q, req_blk_d;
  logic              req_we_q, req_we_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              victim_rr_q, victim_rr_d;
  logic              miss_q, miss_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [BLK_W-1:0] cpu_blk;
  logic [IDX_W-1:0] cpu_idx, req_idx;
  logic [TAG_W-1:0] cpu_tag, req_tag;
  logic             unused_offset;

  assign cpu_blk       = cpu_addr[ADDR_W-1:OFFSET_W];
  assign cpu_idx       = cpu_blk[IDX_W-1:0];
  assign cpu_tag       = cpu_blk[BLK_W-1:IDX_W];
  assign req_idx       = req_blk_q[IDX_W-1:0];
  assign req_tag       = req_blk_q[BLK_W-1:IDX_W];
  assign unused_offset = ^cpu_addr[OFFSET_W-1:0];

  logic [WAYS-1:0][TAG_W-1:0] set_tags;
  logic                       hit, any_invalid;
  logic [WAY_W-1:0]           hit_way, first_invalid;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_set_tags
      assign set_tags[gi] = tag_q[cpu_idx][gi];
    end
  endgenerate

  dcache_tag_match #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W),
    .WAY_W (WAY_W)
  ) u_tag_match (
    .valid_i         (valid_q[cpu_idx]),
    .tags_i          (set_tags),
    .tag_i           (cpu_tag),
    .hit_o           (hit),
    .hit_way_o       (hit_way),
    .first_invalid_o (first_invalid),
    .any_invalid_o   (any_invalid)
  );

  // Single line-write port shared by store hits and refills.
  logic              wr_en, wr_dirty, clr_dirty, rr_adv;
  logic [IDX_W-1:0]  wr_set;
  logic [WAY_W-1:0]  wr_way, victim_w;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    state_d     = state_q;
    req_blk_d   = req_blk_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    victim_d    = victim_q;
    victim_rr_d = victim_rr_q;
    miss_d      = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_en       = 1'b0;
    wr_dirty    = 1'b0;
    wr_set      = req_idx;
    wr_way      = victim_q;
    wr_tag      = req_tag;
    wr_data     = mem.mem_rdata;
    clr_dirty   = 1'b0;
    rr_adv      = 1'b0;
    victim_w    = any_invalid ? first_invalid : rr_q[cpu_idx];

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          req_blk_d   = cpu_blk;
          req_we_d    = cpu_we;
          req_wdata_d = cpu_wdata;
          if (hit) begin
            wr_en       = cpu_we;
            wr_dirty    = 1'b1;
            wr_set      = cpu_idx;
            wr_way      = hit_way;
            wr_tag      = cpu_tag;
            wr_data     = cpu_wdata;
            cpu_rdata_d = cpu_we ? cpu_wdata : data_q[cpu_idx][hit_way];
            state_d     = RESPOND;
          end else begin
            miss_d      = 1'b1;
            victim_d    = victim_w;
            victim_rr_d = !any_invalid;
            if (valid_q[cpu_idx][victim_w] && dirty_q[cpu_idx][victim_w]) begin
              mem_addr_d  = {tag_q[cpu_idx][victim_w], cpu_idx, {OFFSET_W{1'b0}}};
              mem_wdata_d = data_q[cpu_idx][victim_w];
              state_d     = WRITEBACK;
            end else begin
              mem_addr_d = {cpu_blk, {OFFSET_W{1'b0}}};
              state_d    = REFILL;
            end
          end
        end
      end
      WRITEBACK: begin
        if (mem.mem_ack) begin
          clr_dirty  = 1'b1;
          mem_addr_d = {req_blk_q, {OFFSET_W{1'b0}}};
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (mem.mem_ack) begin
          wr_en       = 1'b1;
          wr_dirty    = req_we_q;
          wr_data     = req_we_q ? req_wdata_q : mem.mem_rdata;
          cpu_rdata_d = req_we_q ? req_wdata_q : mem.mem_rdata;
          rr_adv      = victim_rr_q;
          state_d     = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      miss_q      <= 1'b0;
      cpu_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      req_blk_q   <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      victim_q    <= '0;
      victim_rr_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      miss_q      <= miss_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      req_blk_q   <= req_blk_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      victim_q    <= victim_d;
      victim_rr_q <= victim_rr_d;
      if (wr_en) begin
        valid_q[wr_set][wr_way] <= 1'b1;
        dirty_q[wr_set][wr_way] <= wr_dirty;
      end
      if (clr_dirty) dirty_q[req_idx][victim_q] <= 1'b0;
      if (rr_adv) rr_q[req_idx] <= rr_q[req_idx] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_set][wr_way]  <= wr_tag;
      data_q[wr_set][wr_way] <= wr_data;
    end
  end

  assign cpu_rdata     = cpu_rdata_q;
  assign cpu_ready     = (state_q == RESPOND);
  assign miss          = miss_q;
  assign mem.mem_req   = (state_q == WRITEBACK) || (state_q == REFILL);
  assign mem.mem_we    = (state_q == WRITEBACK);
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule
